// File: rtl/out_port_buffer.sv
// Output-port buffer: captures processor OUT writes into a small FWFT FIFO,
// drains them to a device over valid/ready and mirrors the last accepted value.
module out_port_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              out_we,
  input  logic [DATA_W-1:0] out_data,
  output logic              stall_out,
  output logic              dev_valid,
  output logic [DATA_W-1:0] dev_data,
  input  logic              dev_ready,
  output logic [DATA_W-1:0] port_latch,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clear_ovf
);

  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] STALL_CNT = (ADDR_W+1)'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_port_latch;
  logic              r_overflow;

  logic              w_full;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic [ADDR_W:0]   w_count_nxt;

  // Fullness uses the registered count only, so a pop never frees a slot
  // for a push in the same cycle.
  assign w_full = (r_count == FULL_CNT);
  assign w_push = out_we && !w_full;
  assign w_drop = out_we && w_full;
  assign w_pop  = dev_valid && dev_ready;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (ADDR_W+1)'(1);
      2'b01:   w_count_nxt = r_count - (ADDR_W+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_port_latch <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) begin
        r_wr_ptr     <= r_wr_ptr + ADDR_W'(1);
        r_port_latch <= out_data;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by count, so
  // stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= out_data;
    end
  end

  assign dev_valid  = (r_count != '0);
  assign dev_data   = r_mem[r_rd_ptr];
  // One slot of headroom remains for an OUT already in flight when stall rises.
  assign stall_out  = (r_count >= STALL_CNT);
  assign count      = r_count;
  assign port_latch = r_port_latch;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_out_port_buffer.sv
// Self-checking bench for out_port_buffer: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_out_port_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              reset;
  logic              out_we;
  logic [DATA_W-1:0] out_data;
  logic              stall_out;
  logic              dev_valid;
  logic [DATA_W-1:0] dev_data;
  logic              dev_ready;
  logic [DATA_W-1:0] port_latch;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              clear_ovf;

  out_port_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .out_we     (out_we),
    .out_data   (out_data),
    .stall_out  (stall_out),
    .dev_valid  (dev_valid),
    .dev_data   (dev_data),
    .dev_ready  (dev_ready),
    .port_latch (port_latch),
    .count      (count),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: queued values, last accepted value, sticky drop flag.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_latch;
  logic              m_ovf;
  logic [DATA_W-1:0] rx[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".count"},  32'(count), 32'(m_q.size()));
    check({tag, ".valid"},  32'(dev_valid), 32'(m_q.size() != 0));
    check({tag, ".stall"},  32'(stall_out), 32'(m_q.size() >= DEPTH - 1));
    check({tag, ".ovf"},    32'(overflow), 32'(m_ovf));
    check({tag, ".latch"},  32'(port_latch), 32'(m_latch));
    if (m_q.size() != 0) check({tag, ".data"}, 32'(dev_data), 32'(m_q[0]));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_latch = '0;
    m_ovf   = 1'b0;
  endtask

  // One clock: drive inputs, check registered outputs against the model,
  // advance the model by the acceptance rules, then step past the edge.
  task automatic cycle(input string tag, input logic we, input logic [DATA_W-1:0] d,
                       input logic rdy, input logic clr);
    bit full, pop;
    out_we    = we;
    out_data  = d;
    dev_ready = rdy;
    clear_ovf = clr;
    check_outputs(tag);
    full = (m_q.size() == DEPTH);
    pop  = (m_q.size() != 0) && rdy;
    if (pop) begin
      rx.push_back(dev_data);
      void'(m_q.pop_front());
    end
    if (we && !full) begin
      m_q.push_back(d);
      m_latch = d;
    end
    if (we && full) m_ovf = 1'b1;
    else if (clr)   m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; out_we = 1'b0; out_data = '0; dev_ready = 1'b0; clear_ovf = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_outputs("reset");

    // Single push, immediate pop
    cycle("push16", 1'b1, 16'd16, 1'b1, 1'b0);
    check("push16.lat_valid", 32'(dev_valid), 32'd1);
    check("push16.lat_data",  32'(dev_data),  32'd16);
    cycle("pop16", 1'b0, '0, 1'b1, 1'b0);
    check("pop16.count", 32'(count), 32'd0);
    check("pop16.valid", 32'(dev_valid), 32'd0);

    // Fill and stall
    for (int i = 1; i <= 8; i++) begin
      cycle("fill", 1'b1, DATA_W'(i), 1'b0, 1'b0);
      check("fill.stall", 32'(stall_out), 32'(i >= 7));
    end
    check("fill.count8", 32'(count), 32'd8);
    check("fill.ovf0",   32'(overflow), 32'd0);

    // Overflow and clear
    cycle("ovf_push", 1'b1, 16'hBEEF, 1'b0, 1'b0);
    check("ovf.flag",  32'(overflow), 32'd1);
    check("ovf.latch", 32'(port_latch), 32'h0008);
    check("ovf.count", 32'(count), 32'd8);
    cycle("ovf_clr", 1'b0, '0, 1'b0, 1'b1);
    check("ovf.cleared", 32'(overflow), 32'd0);

    // Drain with wrap, pushing 9..12 while draining
    rx.delete();
    cycle("drain", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 9; i <= 12; i++) cycle("drain_push", 1'b1, DATA_W'(i), 1'b1, 1'b0);
    for (int i = 0; i < 12 && m_q.size() != 0; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
    check("drain.rx_len", 32'(rx.size()), 32'd12);
    for (int i = 0; i < 12 && i < rx.size(); i++) check("drain.rx", 32'(rx[i]), 32'(i + 1));
    check("drain.empty", 32'(dev_valid), 32'd0);

    // Simultaneous push and pop at count=3
    for (int i = 0; i < 3; i++) cycle("sim_fill", 1'b1, DATA_W'(16'h100 + i), 1'b0, 1'b0);
    check("sim.count3", 32'(count), 32'd3);
    cycle("sim_pp", 1'b1, 16'h0103, 1'b1, 1'b0);
    check("sim.count", 32'(count), 32'd3);
    check("sim.head",  32'(dev_data), 32'h0101);
    check("sim.latch", 32'(port_latch), 32'h0103);

    // Asynchronous reset mid-operation at count=5
    cycle("pre_rst", 1'b1, 16'h0104, 1'b0, 1'b0);
    cycle("pre_rst", 1'b1, 16'h0105, 1'b0, 1'b0);
    out_we = 1'b0; dev_ready = 1'b0;
    check("pre_rst.count5", 32'(count), 32'd5);
    #2 reset = 1'b0;
    #1;
    check("arst.valid", 32'(dev_valid), 32'd0);
    check("arst.count", 32'(count), 32'd0);
    check("arst.stall", 32'(stall_out), 32'd0);
    check("arst.ovf",   32'(overflow), 32'd0);
    check("arst.latch", 32'(port_latch), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle("rand",
            ($urandom_range(99) < 60),
            DATA_W'($urandom),
            ($urandom_range(99) < ((i / 100) % 2 == 0 ? 30 : 70)),
            ($urandom_range(99) < 4));
    end
    check_outputs("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
